// File: rtl/t03_memresponder.sv
// Purpose : word-addressed memory responder answering CPU read/write requests from an internal array.
// Latency : ack pulses in the (LATENCY+1)th cycle after accept; held requests repeat every LATENCY+2 cycles.
// Backpressure: one transaction at a time; requests are only sampled in IDLE, so the CPU holds read/write until ack.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   read, write       - request strobes (write wins if both high)
//   address, data     - byte address (bits [1:0] ignored) and write data
//   ack, err          - one-cycle completion pulse, out-of-range flag valid with ack
//   dataOut           - read data, updated only when a read completes
//   busy              - high from accept until the end of the ack cycle
module t03_memresponder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] data,
    output logic        ack,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [29:0] addr_q, addr_d;      // word address; byte lane bits are never stored
    logic [31:0] wdat_q, wdat_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [31:0] rdat_q, rdat_d;

    logic [31:0] mem [DEPTH];

    logic                  req;
    logic                  enter_ack;
    logic                  acc_wr;
    logic [29:0]           acc_addr;
    logic [31:0]           acc_data;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  acc_in_range;
    logic                  mem_we;

    // No byte/halfword select exists, so the two lowest address bits are dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^address[1:0];

    // Access-side selection. With zero latency the access happens on the
    // accept edge itself, so the live request is used instead of the latch.
    always_comb begin
        req       = read | write;
        enter_ack = ((state_q == S_IDLE) && req && (LAT == 4'd0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd1));
        if (state_q == S_IDLE) begin
            acc_wr   = write;
            acc_addr = address[31:2];
            acc_data = data;
        end else begin
            acc_wr   = op_wr_q;
            acc_addr = addr_q;
            acc_data = wdat_q;
        end
        acc_idx      = acc_addr[DEPTH_LOG2-1:0];
        acc_in_range = ((acc_addr >> DEPTH_LOG2) == '0);
        // state_q is forced to IDLE by reset, so an aborted write can never commit.
        mem_we       = enter_ack && acc_wr && acc_in_range;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        busy_d  = busy_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_wr_d = write;
                    addr_d  = address[31:2];
                    wdat_d  = data;
                    cnt_d   = LAT;
                    busy_d  = 1'b1;
                    state_d = (LAT == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                // A request seen here is ignored; it is picked up next cycle in IDLE.
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (enter_ack) begin
            ack_d = 1'b1;
            err_d = ~acc_in_range;
            if (!acc_wr) begin
                rdat_d = acc_in_range ? mem[acc_idx] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            addr_q  <= 30'd0;
            wdat_q  <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdat_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdat_q  <= rdat_d;
        end
    end

    // Array contents survive reset and start out undefined.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_data;
        end
    end

    assign ack     = ack_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign dataOut = rdat_q;

endmodule

// File: tb/tb_t03_memresponder.sv
// Purpose : scoreboard bench for t03_memresponder (one instance at LATENCY=2, one at LATENCY=0).
// Latency : checks ack lands in the (LATENCY+1)th cycle after accept and lasts one cycle.
// Backpressure: requests held until ack, then dropped; a held-request run checks back-to-back spacing.
module tb_t03_memresponder;

    localparam int DL  = 8;
    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        read, write;
    logic [31:0] address, data;
    logic        ack, busy, err;
    logic [31:0] dataOut;

    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        ack0, busy0, err0;
    logic [31:0] dout0;

    typedef struct {
        logic        is_wr;
        logic [31:0] dat;
        logic        err;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd;
    int          n_vec;
    int          n_err;

    t03_memresponder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
        .data(data), .ack(ack), .dataOut(dataOut), .busy(busy), .err(err)
    );

    t03_memresponder #(.DEPTH_LOG2(DL), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .read(r0), .write(w0), .address(a0),
        .data(d0), .ack(ack0), .dataOut(dout0), .busy(busy0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance; expectation pushed before driving.
    task automatic txn(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        sb_t         e;
        sb_t         o;
        logic        in_rng;
        int          idx;
        int          n;
        bit          seen;
        in_rng  = ((a >> (DL + 2)) == 0);
        idx     = int'((a >> 2) & ((1 << DL) - 1));
        e.is_wr = wr;
        e.err   = ~in_rng;
        if (wr) begin
            e.dat = last_rd;
            if (in_rng) ref_mem[idx] = d;
        end else begin
            e.dat   = in_rng ? ref_mem[idx] : 32'h0;
            last_rd = e.dat;
        end
        sb.push_back(e);

        @(negedge clk);
        read = rd; write = wr; address = a; data = d;
        seen = 0;
        n    = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (ack) seen = 1;
            else check("busy_wait", {31'd0, busy}, 32'd1);
        end
        read = 1'b0; write = 1'b0;
        if (!seen) begin
            check("ack_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end else begin
            check("latency", n, LAT + 1);
            o = sb.pop_front();
            check(o.is_wr ? "dout_hold_wr" : "dout_rd", dataOut, o.dat);
            check("err", {31'd0, err}, {31'd0, o.err});
            check("busy_ack", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        check("ack_pulse_end", {31'd0, ack}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        n_vec = 0; n_err = 0;
        last_rd = 32'h0;
        rst = 1'b1;
        read = 0; write = 0; address = 0; data = 0;
        r0 = 0; w0 = 0; a0 = 0; d0 = 0;

        repeat (2) @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_dout", dataOut, 32'h0);
        rst = 1'b0;

        txn(1, 0, 32'h20, 32'h11111111);
        txn(1, 0, 32'h0, 32'h0BADC0DE);
        txn(1, 0, 32'h10, 32'hDEADBEEF);
        txn(0, 1, 32'h10, 32'h0);
        txn(1, 0, 32'h400, 32'h12345678);      // aliases word 0 if range check broken
        txn(0, 1, 32'h0, 32'h0);
        txn(0, 1, 32'h400, 32'h0);
        txn(0, 1, 32'h13, 32'h0);              // low byte bits ignored
        
        // Reset in WAIT aborts a pending write.
        @(negedge clk);
        write = 1'b1; address = 32'h20; data = 32'hAAAA5555;
        @(negedge clk);
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_ack", {31'd0, ack}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_err", {31'd0, err}, 32'd0);
        check("rst_mid_dout", dataOut, 32'h0);
        write = 1'b0;
        last_rd = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_ack_in_rst", {31'd0, ack}, 32'd0);
        end
        rst = 1'b0;
        txn(0, 1, 32'h20, 32'h0);              // still 11111111

        txn(1, 1, 32'h8, 32'hCAFEF00D);        // write wins
        txn(0, 1, 32'h8, 32'h0);

        for (int i = 0; i < 8; i++) begin
            txn(1, 0, 32'h100 + 32'(i) * 4, $urandom);
        end
        for (int i = 0; i < 12; i++) begin
            logic [31:0] ra;
            ra = 32'h100 + 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 1) == 1) txn(1, 0, ra, $urandom);
            else txn(0, 1, ra, 32'h0);
        end

        // Zero-latency instance: seed a word, then hold read for 10 cycles.
        @(negedge clk);
        w0 = 1'b1; a0 = 32'h4; d0 = 32'h5A5A5A5A;
        seen = 0; n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (ack0) seen = 1;
        end
        w0 = 1'b0;
        check("l0_wr_latency", n, 1);
        @(negedge clk);
        check("l0_ack_end", {31'd0, ack0}, 32'd0);
        r0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            logic exp_pulse;
            @(negedge clk);
            exp_pulse = (k % 2) == 1;
            check("held_ack", {31'd0, ack0}, {31'd0, exp_pulse});
            check("held_busy", {31'd0, busy0}, {31'd0, exp_pulse});
            if (exp_pulse) begin
                check("held_dout", dout0, 32'h5A5A5A5A);
                check("held_err", {31'd0, err0}, 32'd0);
            end
        end
        r0 = 1'b0;
        repeat (2) @(negedge clk);
        check("held_idle", {31'd0, busy0}, 32'd0);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
